// File: rtl/pb_io_router_pkg.sv
// rtl/pb_io_router_pkg.sv - shared register map constants and types for the PicoBlaze I/O router
package pb_io_router_pkg;

    // Per-channel register offsets within a channel's four-address window
    localparam logic [1:0] OFF_RX   = 2'd0;
    localparam logic [1:0] OFF_TX   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    // Status byte bit positions
    localparam int ST_RX_PRESENT   = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_HOLD_VALID   = 2;
    localparam int ST_RX_UNDERFLOW = 3;
    localparam int ST_TX_DROP      = 4;
    localparam int ST_IRQ_EN       = 5;

    // Control byte bit positions
    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Fixed GPIO port numbers
    localparam logic [7:0] GPIO_IN_PORT  = 8'h00;
    localparam logic [7:0] GPIO_OUT_PORT = 8'h01;

    // One-entry TX holding register states
    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_HELD  = 1'b1
    } tx_state_e;

    // Absolute port_id of register 'off' of channel 'chan'
    function automatic logic [7:0] chan_addr(input logic [7:0] base, input int chan,
                                             input logic [1:0] off);
        return base + 8'(chan * 4) + {6'b000000, off};
    endfunction

endpackage

// File: rtl/pb_uart_chan.sv
// rtl/pb_uart_chan.sv - per-channel TX holding register, sticky flags and irq enable
module pb_uart_chan
    import pb_io_router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_rd_i,
    input  logic       rx_present_i,
    input  logic       tx_wr_i,
    input  logic       ctrl_wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       tx_full_i,
    output logic       rx_ack_o,
    output logic [7:0] tx_data_o,
    output logic       tx_write_o,
    output logic [7:0] status_o,
    output logic       irq_en_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       underflow_q, underflow_d;
    logic       drop_q, drop_d;
    logic       irq_en_q, irq_en_d;
    logic       rx_ack_q, rx_ack_d;
    logic       drain;
    logic       drop_set;

    // State register for the holding FSM, sticky flags and the RX acknowledge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TX_EMPTY;
            hold_q      <= 8'h00;
            underflow_q <= 1'b0;
            drop_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            rx_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
            irq_en_q    <= irq_en_d;
            rx_ack_q    <= rx_ack_d;
        end
    end

    // Next-state logic: holding register drain/accept/drop, sticky set-over-clear, control loads
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        underflow_d = underflow_q;
        drop_d      = drop_q;
        irq_en_d    = irq_en_q;
        rx_ack_d    = rx_rd_i;
        drop_set    = 1'b0;
        // A held byte never leaves while reset is asserted; it is simply lost
        drain       = (state_q == TX_HELD) && !tx_full_i && !reset;
        tx_write_o  = 1'b0;

        case (state_q)
            TX_EMPTY: begin
                if (tx_wr_i) begin
                    state_d = TX_HELD;
                    hold_d  = wr_data_i;
                end
            end
            TX_HELD: begin
                if (drain) begin
                    tx_write_o = 1'b1;
                    // The slot frees on this edge, so a concurrent write refills it
                    if (tx_wr_i) begin
                        hold_d = wr_data_i;
                    end else begin
                        state_d = TX_EMPTY;
                    end
                end else if (tx_wr_i) begin
                    drop_set = 1'b1;
                end
            end
            default: state_d = TX_EMPTY;
        endcase

        if (ctrl_wr_i) begin
            irq_en_d = wr_data_i[CTRL_IRQ_EN_BIT];
            if (wr_data_i[CTRL_CLEAR_BIT]) begin
                underflow_d = 1'b0;
                drop_d      = 1'b0;
            end
        end
        // Events are applied after the clear so a coincident set survives
        if (rx_rd_i && !rx_present_i) begin
            underflow_d = 1'b1;
        end
        if (drop_set) begin
            drop_d = 1'b1;
        end
    end

    // Status byte assembly
    always_comb begin
        status_o                  = 8'h00;
        status_o[ST_RX_PRESENT]   = rx_present_i;
        status_o[ST_TX_FULL]      = tx_full_i;
        status_o[ST_HOLD_VALID]   = (state_q == TX_HELD);
        status_o[ST_RX_UNDERFLOW] = underflow_q;
        status_o[ST_TX_DROP]      = drop_q;
        status_o[ST_IRQ_EN]       = irq_en_q;
    end

    assign rx_ack_o  = rx_ack_q;
    assign tx_data_o = hold_q;
    assign irq_en_o  = irq_en_q;

endmodule

// File: rtl/pb_io_router.sv
// rtl/pb_io_router.sv - PicoBlaze port decoder routing GPIO and multiple UART channels
module pb_io_router
    import pb_io_router_pkg::*;
#(
    parameter int         CHANNELS  = 2,
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic                  read_strobe,
    input  logic                  write_strobe,
    input  logic [7:0]            out_port,
    output logic [7:0]            in_port,
    input  logic [7:0]            gpio_in,
    output logic [7:0]            gpio_out,
    input  logic [8*CHANNELS-1:0] rx_data,
    input  logic [CHANNELS-1:0]   rx_present,
    output logic [CHANNELS-1:0]   rx_ack,
    output logic [8*CHANNELS-1:0] tx_data,
    output logic [CHANNELS-1:0]   tx_write,
    input  logic [CHANNELS-1:0]   tx_full,
    output logic                  irq
);

    logic [7:0]                in_port_q, in_port_d;
    logic [7:0]                gpio_out_q, gpio_out_d;
    logic                      irq_q, irq_d;
    logic [CHANNELS-1:0]       rx_rd;
    logic [CHANNELS-1:0]       tx_wr;
    logic [CHANNELS-1:0]       ctrl_wr;
    logic [CHANNELS-1:0]       irq_en;
    logic [CHANNELS-1:0][7:0]  status;

    // Strobe decode into per-channel register events
    always_comb begin
        rx_rd   = '0;
        tx_wr   = '0;
        ctrl_wr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rx_rd[c]   = read_strobe  && (port_id == chan_addr(BASE_ADDR, c, OFF_RX));
            tx_wr[c]   = write_strobe && (port_id == chan_addr(BASE_ADDR, c, OFF_TX));
            ctrl_wr[c] = write_strobe && (port_id == chan_addr(BASE_ADDR, c, OFF_CTRL));
        end
    end

    // Read mux: write-only and unmapped addresses fall through to zero
    always_comb begin
        in_port_d = 8'h00;
        if (port_id == GPIO_IN_PORT) begin
            in_port_d = gpio_in;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (port_id == chan_addr(BASE_ADDR, c, OFF_RX)) begin
                in_port_d = rx_data[8*c +: 8];
            end
            if (port_id == chan_addr(BASE_ADDR, c, OFF_STAT)) begin
                in_port_d = status[c];
            end
        end
    end

    // GPIO output load and interrupt aggregation
    always_comb begin
        gpio_out_d = gpio_out_q;
        if (write_strobe && (port_id == GPIO_OUT_PORT)) begin
            gpio_out_d = out_port;
        end
        irq_d = |(rx_present & irq_en);
    end

    // Registered read data, LED register and interrupt line
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port_q  <= 8'h00;
            gpio_out_q <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            in_port_q  <= in_port_d;
            gpio_out_q <= gpio_out_d;
            irq_q      <= irq_d;
        end
    end

    assign in_port  = in_port_q;
    assign gpio_out = gpio_out_q;
    assign irq      = irq_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pb_uart_chan u_chan (
            .clk          (clk),
            .reset        (reset),
            .rx_rd_i      (rx_rd[c]),
            .rx_present_i (rx_present[c]),
            .tx_wr_i      (tx_wr[c]),
            .ctrl_wr_i    (ctrl_wr[c]),
            .wr_data_i    (out_port),
            .tx_full_i    (tx_full[c]),
            .rx_ack_o     (rx_ack[c]),
            .tx_data_o    (tx_data[8*c +: 8]),
            .tx_write_o   (tx_write[c]),
            .status_o     (status[c]),
            .irq_en_o     (irq_en[c])
        );
    end

endmodule

// File: tb/tb_pb_io_router.sv
// tb/tb_pb_io_router.sv - directed self-checking bench for pb_io_router
module tb_pb_io_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        read_strobe;
    logic        write_strobe;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [15:0] rx_data;
    logic [1:0]  rx_present;
    logic [1:0]  rx_ack;
    logic [15:0] tx_data;
    logic [1:0]  tx_write;
    logic [1:0]  tx_full;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int pulses0  = 0;
    int pulses1  = 0;
    int snap;

    pb_io_router #(.CHANNELS(2), .BASE_ADDR(8'h10)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .rx_data      (rx_data),
        .rx_present   (rx_present),
        .rx_ack       (rx_ack),
        .tx_data      (tx_data),
        .tx_write     (tx_write),
        .tx_full      (tx_full),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // tx_write pulses are a full cycle wide, so each is seen at exactly one falling edge
    always @(negedge clk) begin
        if (tx_write[0] === 1'b1) pulses0++;
        if (tx_write[1] === 1'b1) pulses1++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL reset_in_port got=%h exp=00", in_port); end
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
        checks++; if (rx_ack !== 2'b00) begin failures++; $display("FAIL reset_rx_ack got=%b exp=00", rx_ack); end
        checks++; if (tx_write !== 2'b00) begin failures++; $display("FAIL reset_tx_write got=%b exp=00", tx_write); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 1'b0;
    endtask

    task automatic test_gpio();
        gpio_in = 8'hA5; port_id = 8'h00; read_strobe = 1'b1;
        step();
        checks++; if (in_port !== 8'hA5) begin failures++; $display("FAIL gpio_in_read got=%h exp=a5", in_port); end
        port_id = 8'h7F;
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL unmapped_read got=%h exp=00", in_port); end
        read_strobe = 1'b0;
        port_id = 8'h01; out_port = 8'h3C; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (gpio_out !== 8'h3C) begin failures++; $display("FAIL gpio_out_load got=%h exp=3c", gpio_out); end
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL write_only_read got=%h exp=00", in_port); end
        port_id = 8'h7F; out_port = 8'hFF; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (gpio_out !== 8'h3C) begin failures++; $display("FAIL unmapped_write got=%h exp=3c", gpio_out); end
    endtask

    task automatic test_rx_read();
        rx_data = 16'h9941; rx_present = 2'b01;
        port_id = 8'h10; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        checks++; if (in_port !== 8'h41) begin failures++; $display("FAIL rx_read_data got=%h exp=41", in_port); end
        checks++; if (rx_ack !== 2'b01) begin failures++; $display("FAIL rx_ack_pulse got=%b exp=01", rx_ack); end
        step();
        checks++; if (rx_ack !== 2'b00) begin failures++; $display("FAIL rx_ack_single got=%b exp=00", rx_ack); end
        rx_present = 2'b00;
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        checks++; if (rx_ack !== 2'b01) begin failures++; $display("FAIL underflow_ack got=%b exp=01", rx_ack); end
        port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h08) begin failures++; $display("FAIL underflow_status got=%h exp=08", in_port); end
        port_id = 8'h13; out_port = 8'h01; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL underflow_clear got=%h exp=00", in_port); end
    endtask

    task automatic test_tx_hold();
        snap = pulses1;
        tx_full = 2'b10;
        port_id = 8'h15; out_port = 8'h55; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'h16;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_write[1] !== 1'b0) begin failures++; $display("FAIL tx_write_while_full cyc=%0d got=%b exp=0", i, tx_write[1]); end
            step();
        end
        checks++; if (in_port !== 8'h06) begin failures++; $display("FAIL hold_status_full got=%h exp=06", in_port); end
        tx_full = 2'b00;
        #1;
        checks++; if (tx_write[1] !== 1'b1) begin failures++; $display("FAIL tx_write_release got=%b exp=1", tx_write[1]); end
        checks++; if (tx_data[15:8] !== 8'h55) begin failures++; $display("FAIL tx_data_release got=%h exp=55", tx_data[15:8]); end
        step();
        checks++; if (tx_write[1] !== 1'b0) begin failures++; $display("FAIL tx_write_after got=%b exp=0", tx_write[1]); end
        checks++; if (in_port !== 8'h04) begin failures++; $display("FAIL hold_status_drain got=%h exp=04", in_port); end
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL hold_status_empty got=%h exp=00", in_port); end
        checks++; if (pulses1 - snap !== 1) begin failures++; $display("FAIL tx1_pulse_count got=%0d exp=1", pulses1 - snap); end
    endtask

    task automatic test_tx_drop();
        snap = pulses0;
        tx_full = 2'b01;
        port_id = 8'h11; out_port = 8'hAA; write_strobe = 1'b1;
        step();
        out_port = 8'hBB;
        step();
        write_strobe = 1'b0; port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h16) begin failures++; $display("FAIL drop_status got=%h exp=16", in_port); end
        checks++; if (tx_write[0] !== 1'b0) begin failures++; $display("FAIL drop_no_write got=%b exp=0", tx_write[0]); end
        tx_full = 2'b00;
        #1;
        checks++; if (tx_data[7:0] !== 8'hAA) begin failures++; $display("FAIL drop_first_byte got=%h exp=aa", tx_data[7:0]); end
        step();
        step();
        checks++; if (in_port !== 8'h10) begin failures++; $display("FAIL drop_sticky got=%h exp=10", in_port); end
        checks++; if (pulses0 - snap !== 1) begin failures++; $display("FAIL tx0_pulse_count got=%0d exp=1", pulses0 - snap); end
        port_id = 8'h13; out_port = 8'h01; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL drop_clear got=%h exp=00", in_port); end
    endtask

    task automatic test_back_to_back();
        snap = pulses0;
        port_id = 8'h11; out_port = 8'hC1; write_strobe = 1'b1;
        step();
        checks++; if (tx_write[0] !== 1'b1 || tx_data[7:0] !== 8'hC1) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/c1", tx_write[0], tx_data[7:0]); end
        out_port = 8'hC2;
        step();
        write_strobe = 1'b0;
        checks++; if (tx_write[0] !== 1'b1 || tx_data[7:0] !== 8'hC2) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/c2", tx_write[0], tx_data[7:0]); end
        step();
        checks++; if (tx_write[0] !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", tx_write[0]); end
        checks++; if (pulses0 - snap !== 2) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses0 - snap); end
        port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL b2b_no_drop got=%h exp=00", in_port); end
    endtask

    task automatic test_irq();
        port_id = 8'h13; out_port = 8'h02; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        rx_present = 2'b01;
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq); end
        port_id = 8'h12;
        step();
        checks++; if (in_port !== 8'h21) begin failures++; $display("FAIL irq_en_status got=%h exp=21", in_port); end
    endtask

    task automatic test_reset_held();
        tx_full = 2'b10;
        port_id = 8'h15; out_port = 8'h77; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        snap = pulses1;
        reset = 1'b1; tx_full = 2'b00;
        #1;
        checks++; if (tx_write !== 2'b00) begin failures++; $display("FAIL reset_held_write got=%b exp=00", tx_write); end
        step();
        reset = 1'b0;
        checks++; if (in_port !== 8'h00 || gpio_out !== 8'h00 || rx_ack !== 2'b00 || tx_write !== 2'b00 || irq !== 1'b0)
            begin failures++; $display("FAIL reset_outputs got=%h/%h/%b/%b/%b exp=00/00/00/00/0", in_port, gpio_out, rx_ack, tx_write, irq); end
        port_id = 8'h16;
        step();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_en got=%b exp=0", irq); end
        checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL reset_hold_empty got=%h exp=00", in_port); end
        step();
        checks++; if (pulses1 - snap !== 0) begin failures++; $display("FAIL reset_lost_byte got=%0d exp=0", pulses1 - snap); end
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
        out_port = 8'h00; gpio_in = 8'h00; rx_data = 16'h0000; rx_present = 2'b00; tx_full = 2'b00;
        test_reset();
        test_gpio();
        test_rx_read();
        test_tx_hold();
        test_tx_drop();
        test_back_to_back();
        test_irq();
        test_reset_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
